// File: rtl/data_mem_responder_if.sv
// Cache-to-memory bus for the data memory responder.
// The master (cache) drives address, data and strobes; the slave returns mem_data.
interface data_mem_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_web;
  logic        io_we;
  logic [31:0] mem_data;

  modport master (
    output mem_addr,
    output mem_write_data,
    output mem_web,
    output io_we,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_write_data,
    input  mem_web,
    input  io_we,
    output mem_data
  );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder for the data cache: block RAM for cacheable words,
// zero-latency peripheral registers for the uncached MMIO window.
module data_mem_responder #(
  parameter int          RAM_ADDR_WID = 14,
  parameter int          CLK_PER_MS   = 100000,
  parameter logic [3:0]  MMIO_SEL     = 4'hf
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  input  logic [15:0]          switches,
  input  logic [4:0]           buttons,
  output logic [15:0]          led,
  output logic [31:0]          seg_data
);

  localparam int PW =
    (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PS_LAST =
    PW'(CLK_PER_MS - 1);

  localparam logic [5:0] OFF_SW    = 6'h00;
  localparam logic [5:0] OFF_BTN   = 6'h01;
  localparam logic [5:0] OFF_LED   = 6'h02;
  localparam logic [5:0] OFF_SEG   = 6'h03;
  localparam logic [5:0] OFF_CYC   = 6'h04;
  localparam logic [5:0] OFF_TMR   = 6'h05;
  localparam logic [5:0] OFF_LATCH = 6'h06;

  // Region and word decode.
  logic                    is_io;
  logic [RAM_ADDR_WID-1:0] widx;
  logic [5:0]              off;
  logic [31:0]             wdata;

  assign is_io = (bus.mem_addr[19:16] == MMIO_SEL);
  assign widx  = bus.mem_addr[RAM_ADDR_WID+1:2];
  assign off   = bus.mem_addr[7:2];
  assign wdata = bus.mem_write_data;

  // Upper address bits and byte offset have no role in this block.
  logic unused_addr;
  assign unused_addr =
    ^{bus.mem_addr[31:20], bus.mem_addr[1:0]};

  // RAM storage and its registered read port.
  logic [31:0] ram_mem [0:(2**RAM_ADDR_WID)-1];
  logic [31:0] ram_rd_q;

  // Write port: no reset, so write-backs during rst still land.
  always_ff @(posedge clk) begin
    if (bus.mem_web && !is_io) begin
      ram_mem[widx] <= wdata;
    end
  end

  // Read port: read-first, output register cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rd_q <= '0;
    end else begin
      ram_rd_q <= ram_mem[widx];
    end
  end

  // MMIO register state.
  logic [15:0]   sw_s1_q, sw_sync_q;
  logic [4:0]    btn_s1_q, btn_sync_q, btn_prev_q;
  logic [15:0]   led_q, led_d;
  logic [31:0]   seg_q, seg_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [31:0]   tmr_q, tmr_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [4:0]    latch_q, latch_d;

  // MMIO stores are blocked while rst is held.
  logic io_wr;
  logic wr_led, wr_seg, wr_tmr, wr_latch;
  logic tick;
  logic [4:0] btn_rise;

  assign io_wr    = bus.io_we && is_io && !rst;
  assign wr_led   = io_wr && (off == OFF_LED);
  assign wr_seg   = io_wr && (off == OFF_SEG);
  assign wr_tmr   = io_wr && (off == OFF_TMR);
  assign wr_latch = io_wr && (off == OFF_LATCH);
  assign tick     = (ps_q == PS_LAST);
  assign btn_rise = btn_sync_q & ~btn_prev_q;

  // Next-state for the writable and counting registers.
  always_comb begin
    led_d   = led_q;
    seg_d   = seg_q;
    cyc_d   = cyc_q + 32'd1;
    tmr_d   = tmr_q;
    ps_d    = tick ? '0 : ps_q + PW'(1);
    latch_d = latch_q;

    if (wr_led) begin
      led_d = wdata[15:0];
    end
    if (wr_seg) begin
      seg_d = wdata;
    end

    if (wr_tmr) begin
      tmr_d = wdata;
      ps_d  = '0;
    end else if (tick && (tmr_q != 32'd0)) begin
      tmr_d = tmr_q - 32'd1;
    end

    if (wr_latch) begin
      latch_d = latch_d & ~wdata[4:0];
    end
    latch_d = latch_d | btn_rise;
  end

  // Two-flop synchronizers plus previous-sample for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q    <= '0;
      sw_sync_q  <= '0;
      btn_s1_q   <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
    end else begin
      sw_s1_q    <= switches;
      sw_sync_q  <= sw_s1_q;
      btn_s1_q   <= buttons;
      btn_sync_q <= btn_s1_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  // Peripheral register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      seg_q   <= '0;
      cyc_q   <= '0;
      tmr_q   <= '0;
      ps_q    <= '0;
      latch_q <= '0;
    end else begin
      led_q   <= led_d;
      seg_q   <= seg_d;
      cyc_q   <= cyc_d;
      tmr_q   <= tmr_d;
      ps_q    <= ps_d;
      latch_q <= latch_d;
    end
  end

  // Combinational MMIO read mux; unmapped offsets read zero.
  logic [31:0] io_rdata;

  always_comb begin
    io_rdata = '0;
    case (off)
      OFF_SW:    io_rdata = {16'b0, sw_sync_q};
      OFF_BTN:   io_rdata = {27'b0, btn_sync_q};
      OFF_LED:   io_rdata = {16'b0, led_q};
      OFF_SEG:   io_rdata = seg_q;
      OFF_CYC:   io_rdata = cyc_q;
      OFF_TMR:   io_rdata = tmr_q;
      OFF_LATCH: io_rdata = {27'b0, latch_q};
      default:   io_rdata = '0;
    endcase
  end

  assign bus.mem_data = is_io ? io_rdata : ram_rd_q;
  assign led          = led_q;
  assign seg_data     = seg_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Inputs change #1 after posedge; outputs are checked later in the same cycle.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] switches;
  logic [4:0]  buttons;
  logic [15:0] led;
  logic [31:0] seg_data;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .RAM_ADDR_WID (14),
    .CLK_PER_MS   (4),
    .MMIO_SEL     (4'hf)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .switches (switches),
    .buttons  (buttons),
    .led      (led),
    .seg_data (seg_data)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A_SW    = 32'h000F_0000;
  localparam logic [31:0] A_BTN   = 32'h000F_0004;
  localparam logic [31:0] A_LED   = 32'h000F_0008;
  localparam logic [31:0] A_SEG   = 32'h000F_000C;
  localparam logic [31:0] A_CYC   = 32'h000F_0010;
  localparam logic [31:0] A_TMR   = 32'h000F_0014;
  localparam logic [31:0] A_LATCH = 32'h000F_0018;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ncyc(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a);
    bus.mem_addr = a;
    #1;
  endtask

  task automatic drv(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic        web,
                     input logic        iowe);
    bus.mem_addr       = a;
    bus.mem_write_data = d;
    bus.mem_web        = web;
    bus.io_we          = iowe;
  endtask

  initial begin
    rst      = 1'b1;
    switches = '0;
    buttons  = '0;
    drv(32'h0, 32'h0, 1'b0, 1'b0);
    ncyc(2);

    rd(A_LED);
    chk("rst_led_rd", bus.mem_data, 32'h0);
    chk("rst_led_port", {16'b0, led}, 32'h0);
    chk("rst_seg", seg_data, 32'h0);
    rd(A_CYC);
    chk("rst_cyc", bus.mem_data, 32'h0);
    rd(A_TMR);
    chk("rst_tmr", bus.mem_data, 32'h0);
    rd(32'h0000_0000);
    chk("rst_ram_q", bus.mem_data, 32'h0);

    rst = 1'b0;
    drv(32'h40, 32'h1111_1111, 1'b1, 1'b0);
    cyc();
    drv(32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0);
    cyc();
    drv(32'h40, 32'h0, 1'b0, 1'b0);
    #1;
    chk("fill_prev_word", bus.mem_data, 32'h1111_1111);
    cyc();
    chk("fill_latency", bus.mem_data, 32'hDEAD_BEEF);

    drv(32'h80, 32'h0000_5555, 1'b1, 1'b0);
    cyc();
    drv(32'h80, 32'h0000_1234, 1'b1, 1'b0);
    cyc();
    drv(32'h80, 32'h0, 1'b0, 1'b0);
    #1;
    chk("read_first_old", bus.mem_data, 32'h0000_5555);
    cyc();
    chk("read_first_new", bus.mem_data, 32'h0000_1234);

    drv(32'h8, 32'hCAFE_F00D, 1'b1, 1'b0);
    cyc();
    drv(A_LED, 32'h7777_7777, 1'b1, 1'b0);
    cyc();
    chk("web_io_led", {16'b0, led}, 32'h0);
    drv(32'h8, 32'h0, 1'b0, 1'b0);
    cyc();
    chk("web_io_ram", bus.mem_data, 32'hCAFE_F00D);

    drv(A_LED, 32'h0000_ABCD, 1'b0, 1'b1);
    cyc();
    drv(A_LED, 32'h0, 1'b0, 1'b0);
    #1;
    chk("led_port", {16'b0, led}, 32'h0000_ABCD);
    chk("led_rd", bus.mem_data, 32'h0000_ABCD);

    drv(32'h8, 32'h0000_0001, 1'b0, 1'b1);
    cyc();
    drv(A_LED, 32'h0, 1'b0, 1'b0);
    #1;
    chk("iowe_ram_ign", bus.mem_data, 32'h0000_ABCD);

    drv(A_SEG, 32'h1234_5678, 1'b0, 1'b1);
    cyc();
    drv(A_SEG, 32'h0, 1'b0, 1'b0);
    #1;
    chk("seg_port", seg_data, 32'h1234_5678);
    chk("seg_rd", bus.mem_data, 32'h1234_5678);
    rd(32'h000F_001C);
    chk("unmapped_rd", bus.mem_data, 32'h0);

    drv(A_TMR, 32'd3, 1'b0, 1'b1);
    cyc();
    drv(A_TMR, 32'h0, 1'b0, 1'b0);
    #1;
    chk("tmr_load", bus.mem_data, 32'd3);
    ncyc(3);
    chk("tmr_hold3", bus.mem_data, 32'd3);
    cyc();
    chk("tmr_2", bus.mem_data, 32'd2);
    ncyc(4);
    chk("tmr_1", bus.mem_data, 32'd1);
    ncyc(4);
    chk("tmr_0", bus.mem_data, 32'd0);
    ncyc(8);
    chk("tmr_sat", bus.mem_data, 32'd0);

    drv(A_TMR, 32'd5, 1'b0, 1'b1);
    cyc();
    drv(A_TMR, 32'h0, 1'b0, 1'b0);
    ncyc(3);
    drv(A_TMR, 32'd9, 1'b0, 1'b1);
    cyc();
    drv(A_TMR, 32'h0, 1'b0, 1'b0);
    #1;
    chk("tmr_wr_wins", bus.mem_data, 32'd9);
    ncyc(3);
    chk("tmr_ps_clr", bus.mem_data, 32'd9);
    cyc();
    chk("tmr_after_wr", bus.mem_data, 32'd8);

    switches = 16'hA5C3;
    buttons  = 5'b00100;
    rd(A_SW);
    cyc();
    chk("sw_lat1", bus.mem_data, 32'h0);
    cyc();
    chk("sw_sync", bus.mem_data, 32'h0000_A5C3);
    rd(A_BTN);
    chk("btn_sync", bus.mem_data, 32'h0000_0004);
    rd(A_LATCH);
    chk("latch_pre", bus.mem_data, 32'h0);
    cyc();
    chk("latch_set", bus.mem_data, 32'h0000_0004);

    buttons = 5'b00000;
    ncyc(3);
    chk("latch_keep", bus.mem_data, 32'h0000_0004);
    buttons = 5'b00100;
    ncyc(2);
    drv(A_LATCH, 32'h0000_0004, 1'b0, 1'b1);
    cyc();
    drv(A_LATCH, 32'h0, 1'b0, 1'b0);
    #1;
    chk("latch_set_wins", bus.mem_data, 32'h0000_0004);
    drv(A_LATCH, 32'h0000_0004, 1'b0, 1'b1);
    cyc();
    drv(A_LATCH, 32'h0, 1'b0, 1'b0);
    #1;
    chk("latch_w1c", bus.mem_data, 32'h0);

    drv(A_LED, 32'h0000_FFFF, 1'b0, 1'b1);
    cyc();
    drv(A_LED, 32'h0, 1'b0, 1'b0);
    #1;
    chk("led_ffff", {16'b0, led}, 32'h0000_FFFF);

    rst = 1'b1;
    drv(A_LED, 32'h0000_1234, 1'b0, 1'b1);
    cyc();
    chk("rst_led_clr", {16'b0, led}, 32'h0);
    drv(32'hC0, 32'hBEEF_0001, 1'b1, 1'b0);
    cyc();
    rst = 1'b0;
    drv(A_CYC, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst_cyc0", bus.mem_data, 32'h0);
    chk("rst_led_blk", {16'b0, led}, 32'h0);
    cyc();
    chk("cyc_1", bus.mem_data, 32'd1);
    ncyc(4);
    chk("cyc_5", bus.mem_data, 32'd5);

    rd(32'h40);
    cyc();
    chk("ram_keep", bus.mem_data, 32'hDEAD_BEEF);
    rd(32'hC0);
    cyc();
    chk("ram_wr_in_rst", bus.mem_data, 32'hBEEF_0001);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the data cache's mem interface (mem_addr / mem_write_data / mem_web -> mem_data).
- Serves cacheable word traffic (line fills and dirty write-backs) from a synchronous block RAM with one-cycle read latency.
- Serves the uncached MMIO region (addr[19:16] == MMIO_SEL) with zero-latency reads from peripheral registers: switches, buttons, LEDs, seven-segment, cycle counter, millisecond down-timer.
- Sits between the cache and the board I/O.

Parameters:
- RAM_ADDR_WID, 14, word-address width of the backing RAM (16384 words = 64 KiB, covers addr[15:2]).
- CLK_PER_MS, 100000, clock cycles per millisecond tick of the down-timer (benches override to a small value, e.g. 4).
- MMIO_SEL, 4'hf, value of addr[19:16] that selects the MMIO region.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- mem_addr  input  32  byte address from the cache; word index is addr[RAM_ADDR_WID+1:2].
- mem_write_data  input  32  write word (RAM write-back data or MMIO store data).
- mem_web  input  1  RAM write enable; honoured only when the address is not MMIO.
- io_we  input  1  MMIO write strobe (CPU store to an uncached address); honoured only when the address is MMIO.
- mem_data  output  32  read data: registered RAM word, or combinational MMIO word.
- switches  input  16  raw board switches (asynchronous).
- buttons  input  5  raw board buttons (asynchronous).
- led  output  16  LED register.
- seg_data  output  32  seven-segment display value register.

Behaviour:
- Region decode: is_io = (mem_addr[19:16] == MMIO_SEL).
- RAM read:
  - On every posedge, ram_q <= RAM[word index].
  - When !is_io, mem_data = ram_q, i.e. the word at the address presented in the previous cycle (1-cycle latency).
  - Read-first: a same-cycle write returns the old word.
- RAM write:
  - At posedge, if mem_web && !is_io, then RAM[word index] <= mem_write_data.
  - mem_web with is_io is ignored.
  - RAM contents are zero at configuration and are NOT cleared by rst.
- MMIO read: when is_io, mem_data is a combinational mux on mem_addr[7:2], with no latency.
- MMIO write: at posedge when io_we && is_io, the selected register updates; unmapped offsets are ignored.
- io_we with !is_io is ignored.
- Register map (byte offset):
  - 0x00 switches (RO): {16'b0, sw_sync}, where sw_sync is a 2-flop synchronizer (2-cycle latency).
  - 0x04 buttons (RO): {27'b0, btn_sync}, also 2-flop synchronized.
  - 0x08 led (RW): low 16 bits are stored; reads return {16'b0, led}.
  - 0x0C seg_data (RW): full 32 bits.
  - 0x10 cycle counter (RO): free-running 32-bit, +1 per cycle, wraps 0xFFFFFFFF -> 0.
  - 0x14 ms timer (RW):
    - A write loads the value and clears the prescaler.
    - The prescaler counts 0..CLK_PER_MS-1; on terminal count, the timer decrements if nonzero and holds at 0 otherwise (saturates).
    - If a write and a tick occur in the same cycle, the write wins.
  - 0x18 button press latch (W1C), bits[4:0]:
    - A bit sets on a rising edge of btn_sync[i].
    - Writing 1 to a bit clears it.
    - If a set and a clear hit the same bit in the same cycle, the set wins.
  - All other offsets read 0.
- Reset (synchronous, clk edge with rst=1): led=0, seg_data=0, cycle counter=0, timer=0, prescaler=0, press latch=0, both synchronizer stages=0, ram_q=0.
  - With rst held, all MMIO writes are blocked; RAM writes still occur, so no in-flight write-back is lost.
  - The first cycle after reset reads mem_data=0 for the RAM path.
- Widths: all counters are unsigned. The prescaler is sized $clog2(CLK_PER_MS).

Test Plan:
- RAM fill latency: write 0xDEADBEEF to 0x0000_0040 with mem_web=1, then present 0x40 with mem_web=0 -> mem_data = 0xDEADBEEF on the next cycle, and the previous word during the presenting cycle.
- Read-first: mem_web=1 to 0x80 with data 0x1234 while old content is 0x5555 -> ram_q shows 0x5555 next cycle; a subsequent read shows 0x1234.
- MMIO isolation: mem_web=1 to 0x000F_0008 -> RAM word 2 unchanged and led unchanged. io_we=1 with data 0xABCD to 0x000F_0008 -> led=0xABCD next cycle, and a read of 0x000F_0008 returns 0x0000ABCD in the same cycle.
- Timer (CLK_PER_MS=4): write 3 to 0x000F_0014 -> timer reads 3, 2, 1, 0 at 4-cycle intervals, then stays at 0. Write at a tick cycle -> the written value is seen, with no decrement.
- Buttons: raise buttons[2] -> switches/buttons reads reflect it after 2 cycles and latch reads 0x4. Write 0x4 to 0x18 in the same cycle as a new edge on bit 2 -> latch stays 0x4. Write 0x4 with no edge -> latch clears to 0.
- Reset mid-operation: after led=0xFFFF and the cycle counter has run, assert rst for 1 cycle -> led=0, counter restarts from 0, RAM words preserved, and io_we is ignored during rst.
